// File: rtl/soc_addr_map_unit.sv
// Runtime-programmable SoC address map: shadow/active rule tables with atomic commit,
// plus a one-stage registered lookup pipeline returning slave index and attributes.
module soc_addr_map_unit #(
  parameter int unsigned NrRules    = 11,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned DefaultIdx = 0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules-1:0][2:0]           RstAttr   = '0,
  localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [11:0]          cfg_addr_i,
  input  logic [63:0]          cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [63:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdxW-1:0]      rsp_idx_o,
  output logic                 rsp_hit_o,
  output logic                 rsp_exec_o,
  output logic                 rsp_cached_o
);

  typedef enum logic [1:0] {StIdle, StDrain, StSwap} state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] shBase_q  [NrRules];
  logic [AddrWidth-1:0] shLen_q   [NrRules];
  logic [2:0]           shAttr_q  [NrRules];
  logic [AddrWidth-1:0] actBase_q [NrRules];
  logic [AddrWidth-1:0] actLen_q  [NrRules];
  logic [2:0]           actAttr_q [NrRules];
  logic                 lock_q;

  logic        cfgRvalid_q;
  logic [63:0] cfgRdata_q, cfgRdata_d;
  logic        cfgErr_q;

  logic            rspValid_q, rspValid_d;
  logic            rspHit_q, rspHit_d;
  logic [IdxW-1:0] rspIdx_q, rspIdx_d;
  logic            rspExec_q, rspExec_d;
  logic            rspCached_q, rspCached_d;

  logic [5:0] cfgIdx;
  logic [1:0] cfgReg;
  logic       isRule, isCommit, isLock, isStatus;
  logic       cfgErr, cfgWrite, busy;

  logic            lkHit, lkExec, lkCached;
  logic [IdxW-1:0] lkIdx;

  assign cfg_gnt_o   = cfg_req_i && (state_q == StIdle);
  assign req_ready_o = (state_q == StIdle) && (!rspValid_q || rsp_ready_i);
  assign busy        = (state_q != StIdle);

  // Rule registers live below 0x800 at 0x20 stride; the slot at +0x18 is a hole.
  always_comb begin
    cfgIdx   = cfg_addr_i[10:5];
    cfgReg   = cfg_addr_i[4:3];
    isRule   = !cfg_addr_i[11] && (cfgReg != 2'd3) && (cfg_addr_i[2:0] == 3'd0) &&
               ({26'd0, cfgIdx} < NrRules);
    isCommit = (cfg_addr_i == 12'h800);
    isLock   = (cfg_addr_i == 12'h808);
    isStatus = (cfg_addr_i == 12'h810);
    cfgErr   = !(isRule || isCommit || isLock || isStatus) || (cfg_we_i && lock_q);
    cfgWrite = cfg_gnt_o && cfg_we_i && !cfgErr;
  end

  always_comb begin
    cfgRdata_d = '0;
    if (!cfg_we_i && !cfgErr) begin
      if (isRule) begin
        for (int i = 0; i < NrRules; i++) begin
          if (cfgIdx == 6'(i)) begin
            case (cfgReg)
              2'd0:    cfgRdata_d = 64'(shBase_q[i]);
              2'd1:    cfgRdata_d = 64'(shLen_q[i]);
              2'd2:    cfgRdata_d = {61'd0, shAttr_q[i]};
              default: cfgRdata_d = '0;
            endcase
          end
        end
      end else if (isStatus) begin
        cfgRdata_d = {62'd0, lock_q, busy};
      end
    end
  end

  // A commit waits for any pending result to leave before swapping tables.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cfgWrite && isCommit) state_d = StDrain;
      StDrain: if (!rspValid_q || rsp_ready_i) state_d = StSwap;
      StSwap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Descending scan so the lowest matching index has the final say.
  always_comb begin
    lkHit    = 1'b0;
    lkIdx    = IdxW'(DefaultIdx);
    lkExec   = 1'b0;
    lkCached = 1'b0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (actAttr_q[i][0] && (actLen_q[i] != '0) && (req_addr_i >= actBase_q[i]) &&
          ((req_addr_i - actBase_q[i]) < actLen_q[i])) begin
        lkHit    = 1'b1;
        lkIdx    = IdxW'(i);
        lkExec   = actAttr_q[i][1];
        lkCached = actAttr_q[i][2];
      end
    end
  end

  always_comb begin
    rspValid_d  = rspValid_q;
    rspHit_d    = rspHit_q;
    rspIdx_d    = rspIdx_q;
    rspExec_d   = rspExec_q;
    rspCached_d = rspCached_q;
    if (req_valid_i && req_ready_o) begin
      rspValid_d  = 1'b1;
      rspHit_d    = lkHit;
      rspIdx_d    = lkIdx;
      rspExec_d   = lkExec;
      rspCached_d = lkCached;
    end else if (rsp_ready_i) begin
      rspValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      lock_q      <= 1'b0;
      cfgRvalid_q <= 1'b0;
      cfgRdata_q  <= '0;
      cfgErr_q    <= 1'b0;
      rspValid_q  <= 1'b0;
      rspHit_q    <= 1'b0;
      rspIdx_q    <= IdxW'(DefaultIdx);
      rspExec_q   <= 1'b0;
      rspCached_q <= 1'b0;
      for (int i = 0; i < NrRules; i++) begin
        shBase_q[i]  <= RstBase[i];
        shLen_q[i]   <= RstLength[i];
        shAttr_q[i]  <= RstAttr[i];
        actBase_q[i] <= RstBase[i];
        actLen_q[i]  <= RstLength[i];
        actAttr_q[i] <= RstAttr[i];
      end
    end else begin
      state_q     <= state_d;
      cfgRvalid_q <= cfg_gnt_o;
      cfgRdata_q  <= cfg_gnt_o ? cfgRdata_d : '0;
      cfgErr_q    <= cfg_gnt_o && cfgErr;
      rspValid_q  <= rspValid_d;
      rspHit_q    <= rspHit_d;
      rspIdx_q    <= rspIdx_d;
      rspExec_q   <= rspExec_d;
      rspCached_q <= rspCached_d;
      if (cfgWrite && isLock && cfg_wdata_i[0]) lock_q <= 1'b1;
      for (int i = 0; i < NrRules; i++) begin
        if (cfgWrite && isRule && (cfgIdx == 6'(i))) begin
          case (cfgReg)
            2'd0:    shBase_q[i] <= AddrWidth'(cfg_wdata_i);
            2'd1:    shLen_q[i]  <= AddrWidth'(cfg_wdata_i);
            2'd2:    shAttr_q[i] <= cfg_wdata_i[2:0];
            default: ;
          endcase
        end
        if (state_q == StSwap) begin
          actBase_q[i] <= shBase_q[i];
          actLen_q[i]  <= shLen_q[i];
          actAttr_q[i] <= shAttr_q[i];
        end
      end
    end
  end

  assign cfg_rvalid_o = cfgRvalid_q;
  assign cfg_rdata_o  = cfgRdata_q;
  assign cfg_err_o    = cfgErr_q;
  assign rsp_valid_o  = rspValid_q;
  assign rsp_hit_o    = rspHit_q;
  assign rsp_idx_o    = rspIdx_q;
  assign rsp_exec_o   = rspExec_q;
  assign rsp_cached_o = rspCached_q;

endmodule
